// File: rtl/sfq_adder_pkg.sv
// Shared types and helpers for the sfq_pipe_adder pipelined adder/subtractor.
// The per-stage data fields are sized by WIDTH inside sfq_adder_stage, because a package cannot take parameters.
package sfq_adder_pkg;

    localparam int unsigned STAT_W = 32;

    // Control part of one pipeline row; its width does not depend on WIDTH.
    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
    } stage_ctl_t;

    function automatic int calc_latency(input int width, input int stage_bits);
        return width / stage_bits;
    endfunction

    // Total bits held by one pipeline row: control plus sum_bits, a_rem and b_rem.
    function automatic int stage_word_w(input int width);
        return $bits(stage_ctl_t) + 3 * width;
    endfunction

endpackage

// File: rtl/sfq_adder_stage.sv
// One clocked row of full-adder cells: resolves STAGE_BITS bits at slot STAGE_IDX.
// The row registers its resolved sum bits, the carry and the valid bit, and skew-buffers the operand bits that are still unresolved.
module sfq_adder_stage
    import sfq_adder_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int STAGE_BITS = 1,
    parameter int STAGE_IDX  = 0,
    parameter bit IS_LAST    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             carry_i,
    input  logic             ovf_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic [WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o
);

    localparam int OFF = STAGE_IDX * STAGE_BITS;
    // Ones over every bit position resolved up to and including this row.
    localparam logic [WIDTH-1:0] DONE_MASK = {WIDTH{1'b1}} >> (WIDTH - OFF - STAGE_BITS);

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] sum_bits;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
    } stage_t;

    stage_t                stage_q;
    stage_t                stage_d;
    logic [STAGE_BITS:0]   carry_chain;
    logic [STAGE_BITS-1:0] slice_sum;

    always_comb begin
        carry_chain    = '0;
        slice_sum      = '0;
        carry_chain[0] = carry_i;
        for (int i = 0; i < STAGE_BITS; i++) begin
            slice_sum[i]     = a_i[OFF+i] ^ b_i[OFF+i] ^ carry_chain[i];
            carry_chain[i+1] = (a_i[OFF+i] & b_i[OFF+i])
                             | (carry_chain[i] & (a_i[OFF+i] ^ b_i[OFF+i]));
        end
    end

    always_comb begin
        stage_d           = '0;
        stage_d.ctl.valid = valid_i;
        stage_d.ctl.carry = carry_chain[STAGE_BITS];
        // Only the row holding the MSB knows carry-in versus carry-out of that bit.
        stage_d.ctl.ovf   = IS_LAST ? (carry_chain[STAGE_BITS] ^ carry_chain[STAGE_BITS-1])
                                    : ovf_i;
        stage_d.sum_bits  = sum_i | (WIDTH'(slice_sum) << OFF);
        stage_d.a_rem     = a_i & ~DONE_MASK;
        stage_d.b_rem     = b_i & ~DONE_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid_o = stage_q.ctl.valid;
    assign carry_o = stage_q.ctl.carry;
    assign ovf_o   = stage_q.ctl.ovf;
    assign sum_o   = stage_q.sum_bits;
    assign a_o     = stage_q.a_rem;
    assign b_o     = stage_q.b_rem;

endmodule

// File: rtl/sfq_pipe_adder.sv
// Bit-level pipelined adder/subtractor: LATENCY rows of clocked full-adder cells, one operation per clock.
// Optional retire statistics (stat_ops, stat_ovf) are built when SFQ_PIPE_STATS_EN is defined.
module sfq_pipe_adder
    import sfq_adder_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int STAGE_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef SFQ_PIPE_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_ops,
    output logic [STAT_W-1:0] stat_ovf
`endif
);

    localparam int LATENCY = calc_latency(WIDTH, STAGE_BITS);

    // Valid semantics: in_valid is sampled at every rising edge with no backpressure; out_valid
    // marks the one cycle a result is presented, exactly LATENCY cycles after its issue.
    logic             v_w   [LATENCY+1];
    logic             c_w   [LATENCY+1];
    logic             ovf_w [LATENCY+1];
    logic [WIDTH-1:0] sum_w [LATENCY+1];
    logic [WIDTH-1:0] a_w   [LATENCY+1];
    logic [WIDTH-1:0] b_w   [LATENCY+1];

    // Subtraction is a + ~b + 1, so cin has no effect while sub=1.
    assign v_w[0]   = in_valid;
    assign c_w[0]   = sub ? 1'b1 : cin;
    assign ovf_w[0] = 1'b0;
    assign sum_w[0] = '0;
    assign a_w[0]   = a;
    assign b_w[0]   = sub ? ~b : b;

    for (genvar k = 0; k < LATENCY; k++) begin : g_row
        sfq_adder_stage #(
            .WIDTH      (WIDTH),
            .STAGE_BITS (STAGE_BITS),
            .STAGE_IDX  (k),
            .IS_LAST    (k == LATENCY - 1)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .valid_i (v_w[k]),
            .carry_i (c_w[k]),
            .ovf_i   (ovf_w[k]),
            .sum_i   (sum_w[k]),
            .a_i     (a_w[k]),
            .b_i     (b_w[k]),
            .valid_o (v_w[k+1]),
            .carry_o (c_w[k+1]),
            .ovf_o   (ovf_w[k+1]),
            .sum_o   (sum_w[k+1]),
            .a_o     (a_w[k+1]),
            .b_o     (b_w[k+1])
        );
    end

    // Every operand bit has been consumed by the final row, so its remainders are always zero.
    logic unused_tail;
    assign unused_tail = ^{a_w[LATENCY], b_w[LATENCY]};

    // Bubble rows may carry stale data; the result is forced to zero outside valid cycles.
    assign out_valid = v_w[LATENCY];
    assign sum       = v_w[LATENCY] ? sum_w[LATENCY] : '0;
    assign cout      = v_w[LATENCY] & c_w[LATENCY];
    assign ovf       = v_w[LATENCY] & ovf_w[LATENCY];

`ifdef SFQ_PIPE_STATS_EN
    logic [STAT_W-1:0] stat_ops_q;
    logic [STAT_W-1:0] stat_ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q <= '0;
            stat_ovf_q <= '0;
        end else if (out_valid) begin
            if (stat_ops_q != '1) begin
                stat_ops_q <= stat_ops_q + 1'b1;
            end
            if (ovf && (stat_ovf_q != '1)) begin
                stat_ovf_q <= stat_ovf_q + 1'b1;
            end
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_ovf = stat_ovf_q;
`endif

endmodule

// File: tb/tb_sfq_pipe_adder.sv
// Scoreboard bench for sfq_pipe_adder: one WIDTH=8 instance with STAGE_BITS=1 and one with STAGE_BITS=4, sharing stimulus.
// Statistics outputs are checked when SFQ_PIPE_STATS_EN is defined.
module tb_sfq_pipe_adder;

    localparam int L1 = 8;
    localparam int L4 = 2;

    typedef struct packed {
        logic [31:0] due;
        logic [7:0]  sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       of;
        int         gap;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;

    logic       ov1, cout1, ovf1;
    logic [7:0] sum1;
    logic       ov4, cout4, ovf4;
    logic [7:0] sum4;
`ifdef SFQ_PIPE_STATS_EN
    logic [31:0] sops1, sovf1, sops4, sovf4;
`endif

    exp_t exp_q1[$];
    exp_t exp_q4[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    int   pulses1  = 0;
    int   pulses4  = 0;
    bit   mon_en   = 1'b0;

    // Hand-computed results for WIDTH=8.
    vec_t vecs[14] = '{
        '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 10},
        '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2},
        '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 2},
        '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 2},
        '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 2},
        '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 0},
        '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 0},
        '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1},
        '{8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 0},
        '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 0},
        '{8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 0},
        '{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0},
        '{8'h01, 8'h80, 1'b1, 1'b1, 8'h81, 1'b0, 1'b1, 0},
        '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0}
    };

    sfq_pipe_adder #(.WIDTH(8), .STAGE_BITS(1)) u_dut_sb1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (ov1),
        .sum       (sum1),
        .cout      (cout1),
        .ovf       (ovf1)
`ifdef SFQ_PIPE_STATS_EN
        ,
        .stat_ops  (sops1),
        .stat_ovf  (sovf1)
`endif
    );

    sfq_pipe_adder #(.WIDTH(8), .STAGE_BITS(4)) u_dut_sb4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (ov4),
        .sum       (sum4),
        .cout      (cout4),
        .ovf       (ovf4)
`ifdef SFQ_PIPE_STATS_EN
        ,
        .stat_ops  (sops4),
        .stat_ovf  (sovf4)
`endif
    );

    // Clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops and compares whenever a DUT presents out_valid.
    task automatic mon_dut(input string tag, input int id, input logic ov, input logic [7:0] s,
                           input logic co, input logic of);
        exp_t e;
        bit   have;
        have = 1'b0;
        e    = '0;
        if (ov) begin
            if (id == 1) pulses1++;
            else         pulses4++;
            if (id == 1 && exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                have = 1'b1;
            end
            if (id == 4 && exp_q4.size() > 0) begin
                e = exp_q4.pop_front();
                have = 1'b1;
            end
            if (!have) begin
                checks++;
                failures++;
                $display("FAIL %s_unexpected: out_valid=1 at cycle %0d, expected none", tag, edge_cnt);
            end else begin
                check({tag, "_sum"},  32'(s),  32'(e.sum));
                check({tag, "_cout"}, 32'(co), 32'(e.cout));
                check({tag, "_ovf"},  32'(of), 32'(e.ovf));
                check({tag, "_cycle"}, 32'(edge_cnt), e.due);
            end
        end else begin
            check({tag, "_idle_zero"}, {22'd0, s, co, of}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_dut("sb1", 1, ov1, sum1, cout1, ovf1);
            mon_dut("sb4", 4, ov4, sum4, cout4, ovf4);
        end
    end

    // Driver tasks.
    task automatic issue(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        sub      = v.sub;
        e.sum    = v.s;
        e.cout   = v.co;
        e.ovf    = v.of;
        e.due    = 32'(edge_cnt + L1);
        exp_q1.push_back(e);
        e.due    = 32'(edge_cnt + L4);
        exp_q4.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst      = 1'b0;
            in_valid = 1'b0;
            a        = 8'($urandom_range(0, 255));
            b        = 8'($urandom_range(0, 255));
            cin      = 1'($urandom_range(0, 1));
            sub      = 1'($urandom_range(0, 1));
        end
    endtask

    // Holds rst with a live operand to show reset wins; drops results not yet presented.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst      = 1'b1;
            in_valid = 1'b1;
            a        = 8'h7F;
            b        = 8'h01;
            cin      = 1'b0;
            sub      = 1'b0;
            while (exp_q1.size() > 0 && exp_q1[$].due > 32'(edge_cnt)) void'(exp_q1.pop_back());
            while (exp_q4.size() > 0 && exp_q4[$].due > 32'(edge_cnt)) void'(exp_q4.pop_back());
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle(1);
        while ((exp_q1.size() > 0 || exp_q4.size() > 0) && n < 64) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_pending", 32'(exp_q1.size() + exp_q4.size()), 32'd0);
    endtask

    initial begin
        int p1;
        int p4;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        sub      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sb1", {28'd0, ov1, 1'b0, cout1, ovf1}, 32'd0);
        check("reset_sum_sb1", 32'(sum1), 32'd0);
        check("reset_sb4", {28'd0, ov4, 1'b0, cout4, ovf4}, 32'd0);
        check("reset_sum_sb4", 32'(sum4), 32'd0);
        mon_en = 1'b1;

        // Directed vectors, isolated first, then back-to-back with a one-cycle gap.
        foreach (vecs[i]) begin
            issue(vecs[i]);
            idle(vecs[i].gap);
        end
        drain();

        // Reset while three ops are in flight, then one op right after reset.
        p1 = pulses1;
        p4 = pulses4;
        issue(vecs[0]);
        issue(vecs[1]);
        issue(vecs[2]);
        do_reset(1);
        issue(vecs[12]);
        drain();
        check("reset_flush_pulses_sb1", 32'(pulses1 - p1), 32'd1);
        check("reset_flush_pulses_sb4", 32'(pulses4 - p4), 32'd3);

`ifdef SFQ_PIPE_STATS_EN
        do_reset(2);
        issue(vecs[2]);
        issue(vecs[4]);
        issue(vecs[0]);
        issue(vecs[1]);
        issue(vecs[3]);
        drain();
        idle(2);
        @(negedge clk);
        check("stat_ops_sb1", sops1, 32'd5);
        check("stat_ovf_sb1", sovf1, 32'd2);
        check("stat_ops_sb4", sops4, 32'd5);
        check("stat_ovf_sb4", sovf4, 32'd2);
        do_reset(1);
        idle(1);
        @(negedge clk);
        check("stat_ops_clr_sb1", sops1, 32'd0);
        check("stat_ovf_clr_sb1", sovf1, 32'd0);
        check("stat_ops_clr_sb4", sops4, 32'd0);
        check("stat_ovf_clr_sb4", sovf4, 32'd0);
`endif

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: run did not finish, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
